// File: rtl/mem_arbiter_if.sv
// Requester handshake and memory bus of mem_arbiter, with arbiter-side (slave) and requester-side (master) modports.
// With MEM_ARB_LOCK_EN defined, also carries the lock0/lock1 inputs.
interface mem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
`ifdef MEM_ARB_LOCK_EN
    logic              lock0;
    logic              lock1;
`endif
    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  lock0, lock1,
`endif
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_q,
        output gnt0, gnt1, ack0, ack1, rdata, busy,
        output mem_addr, mem_data, mem_wren
    );

    modport master (
`ifdef MEM_ARB_LOCK_EN
        output lock0, lock1,
`endif
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_q,
        input  gnt0, gnt1, ack0, ack1, rdata, busy,
        input  mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sequencing two requesters onto one single-port synchronous memory.
// Define MEM_ARB_LOCK_EN to let a granted port keep the memory across back-to-back accesses.
module mem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic         clock,
    input  logic         resetn,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              last_grant;
    logic              we_r;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] rdata_r;
    logic              any_req;
    logic              win;
    logic              locked_req;

    // A port that held its lock through ACK keeps the memory if it asks again at once.
`ifdef MEM_ARB_LOCK_EN
    logic lock_hold;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lock_hold <= 1'b0;
        end else begin
            lock_hold <= (state == ACK) && (owner ? bus.lock1 : bus.lock0);
        end
    end

    assign locked_req = lock_hold && (owner ? bus.req1 : bus.req0);
`else
    assign locked_req = 1'b0;
`endif

    always_comb begin
        any_req = bus.req0 | bus.req1;
        if (locked_req) begin
            win = owner;
        end else if (bus.req0 && bus.req1) begin
            win = ~last_grant;
        end else begin
            win = bus.req1 & ~bus.req0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case can infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_r ? ACK : WAIT;
            WAIT:    if (cnt == '0) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            we_r       <= 1'b0;
            cnt        <= '0;
            addr_r     <= '0;
            data_r     <= '0;
            rdata_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= win;
                        we_r   <= win ? bus.we1 : bus.we0;
                        addr_r <= win ? bus.addr1 : bus.addr0;
                        data_r <= win ? bus.wdata1 : bus.wdata0;
                    end
                end
                ISSUE: begin
                    if (!we_r) cnt <= CNT_W'(RD_LAT - 1);
                end
                WAIT: begin
                    // Counter at zero marks the cycle in which mem_q carries the read word.
                    if (cnt == '0) begin
                        rdata_r <= bus.mem_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    last_grant <= owner;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy     = (state != IDLE);
        bus.gnt0     = (state != IDLE) && !owner;
        bus.gnt1     = (state != IDLE) && owner;
        bus.ack0     = (state == ACK) && !owner;
        bus.ack1     = (state == ACK) && owner;
        bus.mem_wren = (state == ISSUE) && we_r;
    end

    assign bus.mem_addr = addr_r;
    assign bus.mem_data = data_r;
    assign bus.rdata    = rdata_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps plus random traffic against a transaction-level model.
// Build with MEM_ARB_LOCK_EN defined to also exercise the lock inputs.
module tb_mem_arbiter;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic clock = 1'b0;
    logic resetn;
    int   compared   = 0;
    int   mismatched = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return DATA_W'(32'(a) * 32'h9E37 + 32'h1234);
    endfunction

    // Synchronous memory with registered address and RD_LAT cycles of read latency.
    logic [DATA_W-1:0] mem     [DEPTH];
    bit                written [DEPTH];
    logic [DATA_W-1:0] q_pipe  [RD_LAT];

    always @(posedge clock) begin
        if (bus.mem_wren) begin
            mem[bus.mem_addr]     <= bus.mem_data;
            written[bus.mem_addr] <= 1'b1;
        end
        q_pipe[0] <= written[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end

    assign bus.mem_q = q_pipe[RD_LAT-1];

    // Reference model state
    logic [DATA_W-1:0] shadow [DEPTH];
    bit                cur_we    [2];
    logic [ADDR_W-1:0] cur_addr  [2];
    logic [DATA_W-1:0] cur_wdata [2];
    int                last_port;
    int                lock_port;
    int                wr_mode = -1;
    logic [DATA_W-1:0] exp_rdata;
    logic [ADDR_W-1:0] exp_maddr;
    logic [DATA_W-1:0] exp_mdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int p);
        if (p == 0) begin
            bus.we0    = cur_we[0];
            bus.addr0  = cur_addr[0];
            bus.wdata0 = cur_wdata[0];
        end else begin
            bus.we1    = cur_we[1];
            bus.addr1  = cur_addr[1];
            bus.wdata1 = cur_wdata[1];
        end
    endtask

    task automatic set_op(input int p, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cur_we[p]    = we;
        cur_addr[p]  = a;
        cur_wdata[p] = d;
        drive(p);
    endtask

    task automatic new_op(input int p);
        bit we;
        we = (wr_mode < 0) ? 1'($urandom_range(0, 1)) : (wr_mode == 1);
        set_op(p, we, ADDR_W'($urandom), DATA_W'($urandom));
    endtask

    // Cycles from driving a request on an idle arbiter to its ack.
    function automatic int lat(input int p);
        return cur_we[p] ? 2 : RD_LAT + 2;
    endfunction

    function automatic int pick(input bit en0, input bit en1);
        if ((lock_port == 0 && en0) || (lock_port == 1 && en1)) return lock_port;
        if (en0 && en1) return 1 - last_port;
        return en0 ? 0 : 1;
    endfunction

    task automatic model_reset();
        last_port = 1;
        lock_port = -1;
        exp_rdata = '0;
        exp_maddr = '0;
        exp_mdata = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt0"}, 32'(bus.gnt0), 32'(0));
        check({tag, "_gnt1"}, 32'(bus.gnt1), 32'(0));
        check({tag, "_ack0"}, 32'(bus.ack0), 32'(0));
        check({tag, "_ack1"}, 32'(bus.ack1), 32'(0));
        check({tag, "_busy"}, 32'(bus.busy), 32'(0));
        check({tag, "_wren"}, 32'(bus.mem_wren), 32'(0));
        check({tag, "_maddr"}, 32'(bus.mem_addr), 32'(0));
        check({tag, "_mdata"}, 32'(bus.mem_data), 32'(0));
        check({tag, "_rdata"}, 32'(bus.rdata), 32'(0));
    endtask

    task automatic reset_dut(input string tag);
        resetn = 1'b0;
        #1;
        check_zero(tag);
        tick();
        check_zero({tag, "_hold"});
        resetn = 1'b1;
        model_reset();
    endtask

    // Serve n accesses with the enabled ports' requests held high; lock1 is high during the
    // ACK of port 1's first lock1_n accesses.
    task automatic run(input int n, input bit en0, input bit en1, input int lock1_n);
        int t = 0;
        int acks = 0;
        int acks1 = 0;
        int p, l, t_exp, t_iss;
        bit lk1;
        lk1 = (lock1_n > 0);
`ifdef MEM_ARB_LOCK_EN
        bus.lock0 = 1'b0;
        bus.lock1 = lk1;
`endif
        drive(0);
        drive(1);
        bus.req0 = en0;
        bus.req1 = en1;
        p     = pick(en0, en1);
        l     = lat(p);
        t_exp = l;
        while (acks < n) begin
            tick();
            t++;
            t_iss = t_exp - l + 1;
            if (t == t_iss) begin
                exp_maddr = cur_addr[p];
                exp_mdata = cur_wdata[p];
            end
            check("ack0", 32'(bus.ack0), 32'(t == t_exp && p == 0));
            check("ack1", 32'(bus.ack1), 32'(t == t_exp && p == 1));
            check("gnt0", 32'(bus.gnt0), 32'(t >= t_iss && p == 0));
            check("gnt1", 32'(bus.gnt1), 32'(t >= t_iss && p == 1));
            check("busy", 32'(bus.busy), 32'(t >= t_iss));
            check("mem_wren", 32'(bus.mem_wren), 32'(cur_we[p] && t == t_iss));
            check("mem_addr", 32'(bus.mem_addr), 32'(exp_maddr));
            check("mem_data", 32'(bus.mem_data), 32'(exp_mdata));
            if (t == t_exp) begin
                if (cur_we[p]) shadow[cur_addr[p]] = cur_wdata[p];
                else exp_rdata = shadow[cur_addr[p]];
            end
            check("rdata", 32'(bus.rdata), 32'(exp_rdata));
            if (t == t_exp) begin
                acks++;
                last_port = p;
                if (p == 1) acks1++;
                lk1 = (lock1_n > 0) && (acks1 <= lock1_n);
`ifdef MEM_ARB_LOCK_EN
                bus.lock1 = lk1;
                lock_port = (p == 1 && lk1) ? 1 : -1;
`else
                lock_port = -1;
`endif
                new_op(p);
                if (acks == n) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end else begin
                    p     = pick(en0, en1);
                    l     = lat(p);
                    t_exp = t + 1 + l;
                end
            end
            if (!en0) new_op(0);
            if (!en1) new_op(1);
        end
        tick();
`ifdef MEM_ARB_LOCK_EN
        bus.lock1 = 1'b0;
`endif
        lock_port = -1;
        check("idle_busy", 32'(bus.busy), 32'(0));
        check("idle_gnt", 32'({bus.gnt1, bus.gnt0}), 32'(0));
        check("idle_ack", 32'({bus.ack1, bus.ack0}), 32'(0));
        check("idle_maddr", 32'(bus.mem_addr), 32'(exp_maddr));
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        resetn     = 1'b1;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
`ifdef MEM_ARB_LOCK_EN
        bus.lock0  = 1'b0;
        bus.lock1  = 1'b0;
`endif
        for (int i = 0; i < 2; i++) set_op(i, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(ADDR_W'(i));
        model_reset();
        #2;
        reset_dut("reset");

        // Write then read-back of one word from opposite ports
        set_op(0, 1'b1, 7'h05, 16'hA5A5);
        run(1, 1'b1, 1'b0, 0);
        set_op(1, 1'b0, 7'h05, 16'h0000);
        run(1, 1'b0, 1'b1, 0);
        check("readback", 32'(bus.rdata), 32'h0000_A5A5);

        // Simultaneous reads right after reset: port 0 first
        reset_dut("reset2");
        new_op(0);
        new_op(1);
        set_op(0, 1'b0, cur_addr[0], cur_wdata[0]);
        set_op(1, 1'b0, cur_addr[1], cur_wdata[1]);
        run(2, 1'b1, 1'b1, 0);

        // Fairness with both held, then random mixed traffic
        run(4, 1'b1, 1'b1, 0);
        run(30, 1'b1, 1'b1, 0);
        for (int k = 0; k < 12; k++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            run(int'($urandom_range(1, 4)), sel[0], sel[1], 0);
        end

        // Reset during a read's WAIT, then the still-pending request is served
        set_op(0, 1'b0, 7'h05, 16'h0000);
        bus.req0 = 1'b1;
        tick();
        check("mrd_issue_busy", 32'(bus.busy), 32'(1));
        tick();
        check("mrd_wait_gnt0", 32'(bus.gnt0), 32'(1));
        check("mrd_wait_ack0", 32'(bus.ack0), 32'(0));
        #2;
        reset_dut("mid_read");
        run(1, 1'b1, 1'b0, 0);

        // Reset during a write's ISSUE cycle: mem_wren drops and memory is untouched
        a = ADDR_W'($urandom);
        set_op(0, 1'b1, a, ~shadow[a]);
        bus.req0 = 1'b1;
        tick();
        check("mwr_wren", 32'(bus.mem_wren), 32'(1));
        #2;
        bus.req0 = 1'b0;
        reset_dut("mid_write");
        set_op(1, 1'b0, a, '0);
        run(1, 1'b0, 1'b1, 0);

`ifdef MEM_ARB_LOCK_EN
        // Port 1 locks through three writes while port 0 waits
        wr_mode = 1;
        new_op(0);
        run(1, 1'b1, 1'b0, 0);
        new_op(0);
        new_op(1);
        run(4, 1'b1, 1'b1, 2);
        wr_mode = -1;
        run(6, 1'b1, 1'b1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
